rr_bus_mux: RTL and testbench
=============================

Name: rr_bus_mux

Overview:
- Parametrised N-to-1 data multiplexer with a round-robin arbiter and a one-hot decoded channel grant.
- Multiple producer channels compete for a single registered output port using a valid/ready handshake.
- Successor to the team's fixed 4:1 decoder/tri-state mux; generalised in channel count and width, and made sequential with arbitration and back-pressure.
- Sits between per-channel producers and a shared downstream consumer/bus.

Parameters:
- NUM_CH, 4, number of input channels (>= 2).
- DATA_W, 8, data width per channel.
- CH_W, $clog2(NUM_CH), channel index width (localparam, derived).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  NUM_CH  per-channel request/valid.
- in_data  input  NUM_CH*DATA_W  flattened channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  NUM_CH  per-channel accept, one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_data  output  DATA_W  registered selected data.
- out_ch  output  CH_W  index of the channel that sourced out_data.
- out_grant  output  NUM_CH  one-hot decode of out_ch while out_valid=1, else 0.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_data=0 (see optional feature), out_ch=0, out_grant=0.
  - Round-robin pointer ptr=0.
  - in_ready=0 while rst is asserted.
- Load condition: load = (!out_valid || out_ready) && |in_valid.
- Arbitration (combinational):
  - Winner is the first channel with in_valid=1, searching ptr, ptr+1, ... NUM_CH-1, 0, ... ptr-1.
  - in_ready[winner]=1 only when load=1; all other in_ready bits are 0.
  - Accepting a beat means in_valid[i] && in_ready[i] in the same cycle.
- On a clock edge with load=1:
  - out_data <= in_data of the winner.
  - out_ch <= winner.
  - out_valid <= 1.
  - ptr <= (winner+1) wraps to 0 past NUM_CH-1, including non-power-of-2 NUM_CH.
- On a clock edge with load=0 and out_valid && out_ready: out_valid <= 0. out_data and out_ch hold their values.
- If out_valid && !out_ready (stall): the output register and ptr hold; all in_ready bits are 0.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 beat per cycle while out_ready=1. Simultaneous drain and load in one cycle is allowed: out_valid stays 1 with the new beat.
- out_grant is derived from the registered out_ch/out_valid and is glitch-free.
- Fairness: with all channels requesting continuously, grants rotate 0,1,...,NUM_CH-1,0. No channel waits more than NUM_CH-1 grants.
- A channel that drops in_valid before it is accepted is not remembered; no state is kept per channel.
- Reset asserted mid-transfer discards the held beat immediately (out_valid -> 0 asynchronously). After release, arbitration restarts from channel 0.
- Producers must keep in_data stable while in_valid=1 and in_ready=0. The block does not check this.

Optional Feature:
- Macro: RR_BUS_MUX_TRISTATE_EN.
- Defined: out_data is driven 'z whenever out_valid=0, including during reset. The DATA_W-bit register still exists internally; the 'z is applied at the port. This is for direct attachment to a shared bus with other tri-state drivers.
- Undefined: out_data drives the register value at all times. The register resets to 0, and out_data holds the last beat after drain.

Test Plan:
- Reset check: assert rst mid-simulation with out_valid=1 -> out_valid, out_grant, out_ch go to 0 without waiting for clk. out_data=0, or 'z with TRISTATE_EN. First grant after release goes to ch0 when all channels request.
- Round-robin: NUM_CH=4, all in_valid=1, out_ready=1, in_data ch i = 8'hA0+i. Expected out_ch sequence 0,1,2,3,0 on consecutive cycles, out_data A0,A1,A2,A3,A0, out_grant 0001,0010,0100,1000.
- Sparse requests: only ch2 and ch3 valid, ptr=0 -> ch2 wins, then ch3, then ch2. Each in_ready pulse is one-hot on the winning channel.
- Back-pressure: out_ready=0 for 3 cycles while holding beat 8'h55 from ch1 -> out_data/out_ch stable and all in_ready=0. Release out_ready -> next channel (ch2) loads in the same cycle ch1's beat drains.
- Pointer wrap with non-power-of-2 width: NUM_CH=3, DATA_W=16, all requesting -> out_ch cycles 0,1,2,0. Never 3.
- Idle drain: a single beat from ch0, then all in_valid=0 with out_ready=1 -> out_valid falls the next cycle. out_data holds its value without TRISTATE_EN and goes 'z with it.

Source files
------------

// File: rtl/rr_bus_mux_if.sv
// Bundle for rr_bus_mux: per-channel producer requests in, one registered beat out.
// Latency: none, wiring only.
// Backpressure: out_ready from the consumer, in_ready back to each producer.
interface rr_bus_mux_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic [NUM_CH-1:0]        out_grant;
  logic                     out_ready;

  // The mux itself: it accepts channel beats and masters the shared output.
  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_grant
  );

  // The environment: producers plus the downstream consumer.
  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_grant
  );
endinterface

// File: rtl/rr_bus_mux.sv
// N-to-1 round-robin mux into one registered output beat with one-hot grant.
// Latency: 1 cycle accept->out_valid; 1 beat/cycle while out_ready=1.
// Backpressure: out_valid && !out_ready stalls everything (in_ready=0).
// Optional RR_BUS_MUX_TRISTATE_EN: out_data floats to 'z while out_valid=0.
module rr_bus_mux #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
) (
  input logic          clk,
  input logic          rst,
  rr_bus_mux_if.master bus
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [CH_W-1:0]   winner;
  logic [NUM_CH-1:0] win_oh;
  logic              found;
  logic              load;
  int                idx;

  // Search ptr, ptr+1, ... with explicit wrap so non-power-of-2 NUM_CH works.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && bus.in_valid[idx]) begin
        found  = 1'b1;
        winner = CH_W'(idx);
      end
    end
  end

  // Accept only when the output register is free or draining this cycle; never in reset.
  always_comb begin
    win_oh       = NUM_CH'(1) << winner;
    load         = !rst && (!out_valid_q || bus.out_ready) && found;
    bus.in_ready = load ? win_oh : '0;
  end

  // Next state: load a new beat, drain the current one, or hold on stall/idle.
  always_comb begin
    ptr_d       = ptr_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    grant_d     = grant_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_ch_d    = winner;
      out_data_d  = bus.in_data[int'(winner)*DATA_W +: DATA_W];
      grant_d     = win_oh;
      ptr_d       = (winner == CH_W'(NUM_CH - 1)) ? '0 : winner + CH_W'(1);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      grant_d     = '0;
    end
  end

  // State registers; grant is kept as its own flop so the port never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      grant_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      grant_q     <= grant_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_grant = grant_q;
`ifdef RR_BUS_MUX_TRISTATE_EN
  // Release the shared bus whenever no beat is held, reset included.
  assign bus.out_data  = out_valid_q ? out_data_q : 'z;
`else
  assign bus.out_data  = out_data_q;
`endif
endmodule

// File: tb/tb_rr_bus_mux.sv
// Directed bench for rr_bus_mux: table of per-cycle vectors plus hand sequences
// for back-pressure, asynchronous reset and a 3-channel pointer-wrap instance.
module tb_rr_bus_mux;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  rr_bus_mux_if #(.NUM_CH(4), .DATA_W(8))  bus4 ();
  rr_bus_mux_if #(.NUM_CH(3), .DATA_W(16)) bus3 ();

  rr_bus_mux #(.NUM_CH(4), .DATA_W(8))  u_dut4 (.clk(clk), .rst(rst), .bus(bus4.master));
  rr_bus_mux #(.NUM_CH(3), .DATA_W(16)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  iv;
    logic [31:0] idat;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [1:0]  exp_ch;
    logic [7:0]  exp_dat;
    logic [3:0]  exp_gnt;
  } vec_t;

  localparam logic [31:0] D_RR = 32'hA3A2A1A0;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected port value of out_data for the 4-channel instance.
  function automatic logic [7:0] xd(input logic ov, input logic [7:0] d);
`ifdef RR_BUS_MUX_TRISTATE_EN
    return ov ? d : 8'bz;
`else
    return d;
`endif
  endfunction

  task automatic chk_out4(input string tag, input logic ov, input logic [1:0] ch,
                          input logic [7:0] d, input logic [3:0] g);
    chk({tag, ".out_valid"}, 32'(bus4.out_valid), 32'(ov));
    chk({tag, ".out_ch"},    32'(bus4.out_ch),    32'(ch));
    chk({tag, ".out_data"},  32'(bus4.out_data),  32'(xd(ov, d)));
    chk({tag, ".out_grant"}, 32'(bus4.out_grant), 32'(g));
  endtask

  initial begin
    logic [7:0] exp16_unused;
    n_cmp = 0;
    n_bad = 0;
    exp16_unused = '0;

    // in_valid, in_data, out_ready | in_ready, out_valid, out_ch, out_data, out_grant
    vecs[0]  = '{4'b1111, D_RR, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0, 4'b0001};
    vecs[1]  = '{4'b1111, D_RR, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1, 4'b0010};
    vecs[2]  = '{4'b1111, D_RR, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2, 4'b0100};
    vecs[3]  = '{4'b1111, D_RR, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3, 4'b1000};
    vecs[4]  = '{4'b1111, D_RR, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0, 4'b0001};
    vecs[5]  = '{4'b1100, D_RR, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2, 4'b0100};
    vecs[6]  = '{4'b1100, D_RR, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3, 4'b1000};
    vecs[7]  = '{4'b1100, D_RR, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2, 4'b0100};
    vecs[8]  = '{4'b0000, D_RR, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA2, 4'b0000};
    vecs[9]  = '{4'b0001, D_RR, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0, 4'b0001};
    vecs[10] = '{4'b0000, D_RR, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA0, 4'b0000};

    // Reset with every channel requesting: nothing may be accepted.
    rst = 1'b1;
    bus4.in_valid = 4'b1111;
    bus4.in_data  = D_RR;
    bus4.out_ready = 1'b1;
    bus3.in_valid = '0;
    bus3.in_data  = '0;
    bus3.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.in_ready", 32'(bus4.in_ready), 32'h0);
    chk_out4("reset", 1'b0, 2'd0, 8'h00, 4'b0000);
    rst = 1'b0;

    // Round-robin, sparse requests, idle drain.
    for (int i = 0; i < 11; i++) begin
      bus4.in_valid  = vecs[i].iv;
      bus4.in_data   = vecs[i].idat;
      bus4.out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d.in_ready", i), 32'(bus4.in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      chk_out4($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_ch,
               vecs[i].exp_dat, vecs[i].exp_gnt);
    end

    // Back-pressure: ptr=1, ch1 loads 8'h55 with out_ready=0.
    bus4.in_valid  = 4'b0010;
    bus4.in_data   = 32'h0000_5500;
    bus4.out_ready = 1'b0;
    #1;
    chk("bp_load.in_ready", 32'(bus4.in_ready), 32'b0010);
    @(posedge clk);
    #1;
    chk_out4("bp_load", 1'b1, 2'd1, 8'h55, 4'b0010);
    for (int c = 0; c < 3; c++) begin
      bus4.in_valid = 4'b1111;
      bus4.in_data  = D_RR;
      #1;
      chk($sformatf("bp_stall%0d.in_ready", c), 32'(bus4.in_ready), 32'h0);
      @(posedge clk);
      #1;
      chk_out4($sformatf("bp_stall%0d", c), 1'b1, 2'd1, 8'h55, 4'b0010);
    end
    bus4.out_ready = 1'b1;
    #1;
    chk("bp_release.in_ready", 32'(bus4.in_ready), 32'b0100);
    @(posedge clk);
    #1;
    chk_out4("bp_release", 1'b1, 2'd2, 8'hA2, 4'b0100);

    // Reset mid-transfer with a beat held: must clear without a clock edge.
    bus4.out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst.in_ready", 32'(bus4.in_ready), 32'h0);
    chk_out4("arst", 1'b0, 2'd0, 8'h00, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus4.in_valid  = 4'b1111;
    bus4.out_ready = 1'b1;
    #1;
    chk("post_rst.in_ready", 32'(bus4.in_ready), 32'b0001);
    @(posedge clk);
    #1;
    chk_out4("post_rst", 1'b1, 2'd0, 8'hA0, 4'b0001);
    bus4.in_valid = 4'b0000;

    // Non-power-of-2 instance: pointer must wrap 2 -> 0.
    bus3.in_valid  = 3'b111;
    bus3.in_data   = {16'h1002, 16'h1001, 16'h1000};
    bus3.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("wrap%0d.out_valid", k), 32'(bus3.out_valid), 32'h1);
      chk($sformatf("wrap%0d.out_ch", k), 32'(bus3.out_ch), 32'(k % 3));
      chk($sformatf("wrap%0d.out_data", k), 32'(bus3.out_data), 32'h1000 + 32'(k % 3));
      chk($sformatf("wrap%0d.out_grant", k), 32'(bus3.out_grant), 32'(3'b001 << (k % 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
